// File: rtl/playfield_pkg.sv
// Shared types and dimensions for the playfield store.
// Optional build macro PLAYFIELD_LINE_STATS_EN is consumed by playfield_store.
package playfield_pkg;

    localparam int ROWS = 16;
    localparam int COLS = 16;

    // One cell brightness level, 0 = off.
    typedef logic [1:0] level_t;

    // One playfield row; column c occupies bits [2c+1:2c].
    typedef level_t [COLS-1:0] row_t;

    // Clear-sequence controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/row_full_detect.sv
// Combinational full-row test: a row is full when every cell is at or
// above the occupancy threshold.
module row_full_detect
    import playfield_pkg::*;
(
    input  row_t   row,
    input  level_t occ_level,
    output logic   full
);

    // Reduce the per-cell threshold comparisons to one flag.
    always_comb begin
        // NOTE: assigning a default before the loop keeps this purely
        // combinational; a path that leaves full unassigned would infer a latch.
        full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (row[c] < occ_level) begin
                full = 1'b0;
            end
        end
    end

endmodule

// File: rtl/playfield_store.sv
// 16x16 playfield of 2-bit levels with cell writes, registered row reads and
// a row-by-row full-line scan that collapses cleared rows downward.
// Build macro PLAYFIELD_LINE_STATS_EN: when defined, total_lines is a
// saturating lifetime count of cleared rows; otherwise it is tied to 0.
module playfield_store
#(
    parameter int unsigned OCC_LEVEL = 1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_row,
    input  logic [3:0]  wr_col,
    input  logic [1:0]  wr_level,
    input  logic        clr_req,
    output logic        busy,
    output logic        done,
    output logic [4:0]  lines_cleared,
    input  logic [3:0]  rd_row,
    output logic [31:0] rd_data,
    output logic [15:0] total_lines
);

    import playfield_pkg::*;

    state_t     state;
    logic [3:0] scan_r;     // row currently under test
    logic [3:0] shift_k;    // destination row of the current shift step
    logic [4:0] scan_cnt;   // full rows found during the running scan
    logic       rst_done;   // low until the first cycle out of reset
    logic       row_full;
    logic       wr_fire;
    row_t       grid [ROWS];

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign wr_ready = (state == ST_IDLE) && rst_done;
    assign wr_fire  = wr_valid && wr_ready;

    row_full_detect u_row_full_detect (
        .row       (grid[scan_r]),
        .occ_level (level_t'(OCC_LEVEL)),
        .full      (row_full)
    );

    // Clear-sequence controller: scan bottom-up, shift on each full row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            state         <= ST_IDLE;
            scan_r        <= 4'd15;
            shift_k       <= 4'd15;
            scan_cnt      <= '0;
            lines_cleared <= '0;
            rst_done      <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state    <= ST_SCAN;
                        scan_r   <= 4'd15;
                        scan_cnt <= '0;
                    end
                end
                ST_SCAN: begin
                    if (row_full) begin
                        state    <= ST_SHIFT;
                        shift_k  <= scan_r;
                        scan_cnt <= scan_cnt + 5'd1;
                    end else if (scan_r == 4'd0) begin
                        state         <= ST_DONE;
                        lines_cleared <= scan_cnt;
                    end else begin
                        scan_r <= scan_r - 4'd1;
                    end
                end
                ST_SHIFT: begin
                    // Rescan the same row: it now holds the row from above.
                    if (shift_k == 4'd0) begin
                        state <= ST_SCAN;
                    end else begin
                        shift_k <= shift_k - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Cell array: accepted writes in IDLE, one row move per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the array is explicitly cleared on reset because a reset
            // mid-scan must leave a blank playfield; this keeps it in flops
            // rather than a RAM macro.
            for (int i = 0; i < ROWS; i++) begin
                grid[i] <= '0;
            end
        end else if (wr_fire) begin
            grid[wr_row][wr_col] <= wr_level;
        end else if (state == ST_SHIFT) begin
            if (shift_k == 4'd0) begin
                grid[0] <= '0;
            end else begin
                grid[shift_k] <= grid[shift_k - 4'd1];
            end
        end
    end

    // Registered display read of the live array, one cycle behind rd_row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= grid[rd_row];
        end
    end

`ifdef PLAYFIELD_LINE_STATS_EN
    logic [16:0] total_sum;

    assign total_sum = {1'b0, total_lines} + 17'(lines_cleared);

    // Lifetime cleared-row counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_lines <= '0;
        end else if (state == ST_DONE) begin
            total_lines <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end
`else
    assign total_lines = '0;
`endif

endmodule

// File: tb/tb_playfield_store.sv
// Directed self-checking bench for playfield_store.
// Honours PLAYFIELD_LINE_STATS_EN for the expected total_lines value.
module tb_playfield_store;

`ifdef PLAYFIELD_LINE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_row;
    logic [3:0]  wr_col;
    logic [1:0]  wr_level;
    logic        clr_req;
    logic        busy;
    logic        done;
    logic [4:0]  lines_cleared;
    logic [3:0]  rd_row;
    logic [31:0] rd_data;
    logic [15:0] total_lines;

    int n_checks;
    int n_pass;
    int running_total;

    playfield_store #(.OCC_LEVEL(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_row        (wr_row),
        .wr_col        (wr_col),
        .wr_level      (wr_level),
        .clr_req       (clr_req),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .rd_row        (rd_row),
        .rd_data       (rd_data),
        .total_lines   (total_lines)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_cell(input int r, input int c, input int lvl);
        int n;
        n = 0;
        while (!wr_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!wr_ready) check("write_ready_timeout", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_row   = 4'(r);
        wr_col   = 4'(c);
        wr_level = 2'(lvl);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic fill_row(input int r, input int lvl);
        for (int c = 0; c < 16; c++) write_cell(r, c, lvl);
    endtask

    task automatic read_row(input int r, output logic [31:0] data);
        rd_row = 4'(r);
        @(posedge clk); #1;
        data = rd_data;
    endtask

    // Waits for done with a cycle budget; n counts state cycles since clr_req.
    task automatic wait_done(inout int n);
        while (!done && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Checks the DONE cycle and the following IDLE cycle.
    task automatic check_done(input string tag, input int n, input int exp_cycles, input int exp_lines);
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
        check({tag, "_lines"}, 32'(lines_cleared), 32'(exp_lines));
        running_total += exp_lines;
        @(posedge clk); #1;
        check({tag, "_done_pulse_len"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_total"}, 32'(total_lines), STATS ? 32'(running_total) : 32'd0);
    endtask

    task automatic run_clear(input string tag, input int exp_cycles, input int exp_lines);
        int n;
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        n = 1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_ready_low"}, 32'(wr_ready), 32'd0);
        wait_done(n);
        check_done(tag, n, exp_cycles, exp_lines);
    endtask

    initial begin
        logic [31:0] d;
        int          n;
        int          done_seen;

        n_checks      = 0;
        n_pass        = 0;
        running_total = 0;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_row   = '0;
        wr_col   = '0;
        wr_level = '0;
        clr_req  = 1'b0;
        rd_row   = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lines", 32'(lines_cleared), 32'd0);
        check("rst_total", 32'(total_lines), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_wr_ready", 32'(wr_ready), 32'd1);

        // Single full bottom row: scan, 16-cycle shift, full rescan, done.
        fill_row(15, 3);
        read_row(15, d);
        check("t1_row15_before", d, 32'hFFFF_FFFF);
        run_clear("t1", 34, 1);
        read_row(15, d);
        check("t1_row15_after", d, 32'd0);

        // Two full rows with a lone cell above collapsing to the bottom.
        fill_row(14, 1);
        fill_row(15, 3);
        write_cell(13, 5, 2);
        run_clear("t2", 51, 2);
        for (int r = 0; r < 15; r++) begin
            read_row(r, d);
            check($sformatf("t2_row%0d", r), d, 32'd0);
        end
        rd_row = 4'd15;
        #2;
        check("t2_rd_latency_hold", rd_data, 32'd0);
        @(posedge clk); #1;
        check("t2_row15", rd_data, 32'h0000_0800);

        // Only the top row full: one-cycle shift at r=0.
        fill_row(0, 2);
        run_clear("t3", 19, 1);
        read_row(0, d);
        check("t3_row0", d, 32'd0);
        read_row(15, d);
        check("t3_row15_kept", d, 32'h0000_0800);

        // Completing write and clr_req in the same cycle; stalled writes.
        for (int c = 0; c < 15; c++) write_cell(15, c, 3);
        check("t4_ready_before", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_row   = 4'd15;
        wr_col   = 4'd15;
        wr_level = 2'd3;
        clr_req  = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        n = 1;
        check("t4_busy", 32'(busy), 32'd1);
        wr_valid = 1'b1;
        wr_row   = 4'd3;
        wr_col   = 4'd3;
        wr_level = 2'd2;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_stall_ready%0d", i), 32'(wr_ready), 32'd0);
            clr_req = (i == 2);
            @(posedge clk); #1;
            n++;
        end
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        wait_done(n);
        check_done("t4", n, 34, 1);
        @(posedge clk); #1;
        check("t4_no_restart", 32'(busy), 32'd0);
        read_row(15, d);
        check("t4_row15", d, 32'd0);
        read_row(3, d);
        check("t4_row3_untouched", d, 32'd0);

        // Row with one empty cell is not full.
        for (int c = 0; c < 16; c++) write_cell(15, c, (c == 9) ? 0 : 1);
        run_clear("t5", 17, 0);
        read_row(15, d);
        check("t5_row15_kept", d, 32'h5551_5555);

        // Reset in the middle of a shift aborts with no done pulse.
        write_cell(15, 9, 1);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        done_seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("t6_busy_mid_shift", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        if (done) done_seen++;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_wr_ready", 32'(wr_ready), 32'd0);
        check("t6_rst_lines", 32'(lines_cleared), 32'd0);
        check("t6_rst_total", 32'(total_lines), 32'd0);
        @(posedge clk); #1;
        if (done) done_seen++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (done) done_seen++;
        check("t6_wr_ready_after", 32'(wr_ready), 32'd1);
        check("t6_no_done", 32'(done_seen), 32'd0);
        running_total = 0;
        for (int r = 0; r < 16; r++) begin
            read_row(r, d);
            check($sformatf("t6_row%0d_zero", r), d, 32'd0);
        end

        // Three scans clearing 1, 2 and 4 rows accumulate into total_lines.
        fill_row(15, 1);
        run_clear("t7a", 34, 1);
        fill_row(14, 2);
        fill_row(15, 2);
        run_clear("t7b", 51, 2);
        for (int r = 12; r < 16; r++) fill_row(r, 3);
        run_clear("t7c", 85, 4);
        check("t7_total", 32'(total_lines), STATS ? 32'd7 : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
